// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package adder_pkg;

    // Controller states; a single bit is enough for the two-state machine.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Number of digit cycles needed to cover the operand width.
    function automatic int ndig(input int width, input int digit);
        return (digit > 0) ? (width / digit) : 0;
    endfunction

    // Counter width able to hold 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/adder_digit_slice.sv
// DIGIT-bit combinational ripple-carry slice built from explicit full adders.
module adder_digit_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum[i]  = x[i] ^ y[i] ^ c[i];
        assign c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    // Carry into the top bit of the slice; on the last digit this is the
    // carry into the word MSB, used for signed overflow.
    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/adder_digit_serial.sv
// Multi-cycle digit-serial adder/subtractor: one DIGIT-bit slice, LSB digit
// first, start/busy/done handshake, registered result held until next op.
module adder_digit_serial
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW   = cnt_w(NDIG);
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("adder_digit_serial: DIGIT must be >= 1 and divide WIDTH");
    end

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             last;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             carry;
    int               dig_idx;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT-1:0] dig_sum;
    logic             slice_co;
    logic             slice_c_msb;

    // Select the current digit and merge the slice sum into the accumulator;
    // the index is clamped so the idle counter value never selects past WIDTH.
    always_comb begin
        dig_idx = (int'(cnt) < NDIG) ? int'(cnt) * DIGIT : 0;
        dig_a   = op_a[dig_idx +: DIGIT];
        dig_b   = op_b[dig_idx +: DIGIT];
        acc_nxt = acc;
        acc_nxt[dig_idx +: DIGIT] = dig_sum;
    end

    adder_digit_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .x     (dig_a),
        .y     (dig_b),
        .ci    (carry),
        .sum   (dig_sum),
        .co    (slice_co),
        .c_msb (slice_c_msb)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST_CNT) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Digit counter and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= step & last;
            if (load) begin
                cnt  <= '0;
                busy <= 1'b1;
            end else if (step) begin
                cnt <= cnt + CW'(1);
                if (last) begin
                    busy <= 1'b0;
                end
            end
        end
    end

    // Operand capture (subtract folds into ~b plus inverted borrow) and the
    // per-digit carry/accumulator update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            acc   <= '0;
        end else if (load) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= cin ^ sub;
            acc   <= '0;
        end else if (step) begin
            carry <= slice_co;
            acc   <= acc_nxt;
        end
    end

    // Result registers change only on the final digit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (step && last) begin
            s    <= acc_nxt;
            cout <= slice_co;
            ovf  <= slice_c_msb ^ slice_co;
        end
    end

endmodule

// File: tb/tb_adder_digit_serial.sv
// Scoreboard bench for two configurations: WIDTH=8/DIGIT=4 and WIDTH=4/DIGIT=1.
module tb_adder_digit_serial;

    typedef struct {
        logic [7:0] s;
        logic       cout;
        logic       ovf;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] start, sub, cin, busy, done, cout, ovf;
    logic [7:0] a0, b0, s0;
    logic [3:0] a1, b1, s1;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] last_s [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    adder_digit_serial #(.WIDTH(8), .DIGIT(4)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .sub(sub[0]),
        .a(a0), .b(b0), .cin(cin[0]), .busy(busy[0]), .done(done[0]),
        .s(s0), .cout(cout[0]), .ovf(ovf[0])
    );

    adder_digit_serial #(.WIDTH(4), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .sub(sub[1]),
        .a(a1), .b(b1), .cin(cin[1]), .busy(busy[1]), .done(done[1]),
        .s(s1), .cout(cout[1]), .ovf(ovf[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] get_s(input int i);
        return (i == 0) ? s0 : {4'b0, s1};
    endfunction

    function automatic int nd(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    // Reference: plain integer arithmetic, unsigned for carry, signed for overflow.
    function automatic exp_t model(input int i, input bit sb, input int av, input int bv, input int c);
        int w, m, half, r, sa, sbv, rs;
        exp_t e;
        w    = (i == 0) ? 8 : 4;
        m    = (1 << w) - 1;
        half = 1 << (w - 1);
        r    = sb ? av - bv - c : av + bv + c;
        e.cout = sb ? (r >= 0) : (r > m);
        e.s    = 8'(r & m);
        sa   = (av >= half) ? av - (1 << w) : av;
        sbv  = (bv >= half) ? bv - (1 << w) : bv;
        rs   = sb ? sa - sbv - c : sa + sbv + c;
        e.ovf = (rs > half - 1) || (rs < -half);
        e.acc = 0;
        return e;
    endfunction

    task automatic set_ops(input int i, input bit sb, input int av, input int bv, input bit c);
        sub[i] = sb;
        cin[i] = c;
        if (i == 0) begin
            a0 = 8'(av);
            b0 = 8'(bv);
        end else begin
            a1 = 4'(av);
            b1 = 4'(bv);
        end
    endtask

    // Call at a negedge with the instance idle; returns just after the accepting edge.
    task automatic issue(input int i, input bit sb, input int av, input int bv, input bit c);
        exp_t e;
        set_ops(i, sb, av, bv, c);
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        e = model(i, sb, av, bv, int'(c));
        e.acc = cyc;
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
        start[i] = 1'b0;
        set_ops(i, ~sb, ~av, ~bv, ~c);
    endtask

    // Waits (bounded) for done; checks busy length and result hold during RUN.
    // With poke set, a second start with different operands is driven while busy.
    task automatic wait_done(input int i, input bit poke);
        int  bc;
        bit  seen;
        bc   = 0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done[i]) begin
                seen = 1;
                break;
            end
            if (busy[i]) begin
                bc++;
                chk($sformatf("hold%0d", i), {24'b0, get_s(i)}, {24'b0, last_s[i]});
            end
            if (poke && k == 0) begin
                set_ops(i, 1'b1, 0, 8'hFF, 1'b1);
                start[i] = 1'b1;
            end
            if (poke && k == 1) start[i] = 1'b0;
        end
        start[i] = 1'b0;
        chk($sformatf("done_seen%0d", i), {31'b0, seen}, 32'd1);
        chk($sformatf("busy_cycles%0d", i), bc, nd(i));
    endtask

    // Output side of the scoreboard.
    task automatic check_done(input int i);
        exp_t e;
        int   sz;
        sz = (i == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            chk($sformatf("spurious_done%0d", i), 32'd1, 32'd0);
        end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("s%0d", i), {24'b0, get_s(i)}, {24'b0, e.s});
            chk($sformatf("cout%0d", i), {31'b0, cout[i]}, {31'b0, e.cout});
            chk($sformatf("ovf%0d", i), {31'b0, ovf[i]}, {31'b0, e.ovf});
            chk($sformatf("latency%0d", i), cyc - e.acc, nd(i));
            last_s[i] = e.s;
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (done[i] === 1'b1) check_done(i);
        end
    end

    task automatic chk_idle(input int i, input string tag);
        chk({tag, "_busy"}, {31'b0, busy[i]}, 32'd0);
        chk({tag, "_done"}, {31'b0, done[i]}, 32'd0);
        chk({tag, "_s"}, {24'b0, get_s(i)}, 32'd0);
        chk({tag, "_cout"}, {31'b0, cout[i]}, 32'd0);
        chk({tag, "_ovf"}, {31'b0, ovf[i]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        start = '0; sub = '0; cin = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        last_s[0] = '0;
        last_s[1] = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle(0, "rst8");
        chk_idle(1, "rst4");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add with signed overflow.
        issue(0, 1'b0, 8'h5A, 8'h3C, 1'b0);
        wait_done(0, 1'b0);
        @(negedge clk);

        // Wrap with carry-in; a start while busy must be ignored.
        issue(0, 1'b0, 8'hFF, 8'h01, 1'b1);
        wait_done(0, 1'b1);
        repeat (4) @(negedge clk);

        // Subtract cases.
        issue(0, 1'b1, 8'h10, 8'h20, 1'b0);
        wait_done(0, 1'b0);
        @(negedge clk);
        issue(0, 1'b1, 8'h80, 8'h01, 1'b1);
        wait_done(0, 1'b0);
        @(negedge clk);

        // Reset after the first RUN edge aborts the operation.
        issue(0, 1'b0, 8'h5A, 8'h3C, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q0.delete();
        last_s[0] = '0;
        last_s[1] = '0;
        @(negedge clk);
        chk_idle(0, "abort_in");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle(0, "abort_out");
        repeat (4) @(negedge clk);
        issue(0, 1'b0, 8'h12, 8'h34, 1'b1);
        wait_done(0, 1'b0);
        @(negedge clk);

        // Bit-serial config, then back-to-back start in the done cycle.
        issue(1, 1'b0, 4'h7, 4'h1, 1'b0);
        wait_done(1, 1'b0);
        issue(1, 1'b0, 4'h3, 4'h4, 1'b1);
        wait_done(1, 1'b0);
        @(negedge clk);

        // Random mix on both configurations.
        for (int n = 0; n < 12; n++) begin
            int i;
            i = n % 2;
            issue(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, (i == 0) ? 255 : 15)),
                  int'($urandom_range(0, (i == 0) ? 255 : 15)), 1'($urandom_range(0, 1)));
            wait_done(i, 1'b0);
            if (n % 3 == 0) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("q8_empty", q0.size(), 32'd0);
        chk("q4_empty", q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
